fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS32 core; sits directly upstream of the IF/ID consumer (decode, control unit, register-file read).
- Owns the PC and issues requests on a req/ack instruction-memory port.
- Buffers one returned instruction when decode stalls, and presents the IF/ID register (oIR, oPC, oPC4, ovalid) to decode.
- Accepts redirects (taken branch/jump/jr) from the branch-resolution stage and flushes wrong-path work.

Parameters:
- ADDR_W, 8, instruction byte-address width; PC wraps modulo 2^ADDR_W.
- DATA_W, 32, instruction width.
- RESET_PC, 0, first fetch address after reset.
- NOP, 32'h0000_0000, instruction word driven on oIR for bubbles.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  ADDR_W  fetch address.
- imem_ack  in  1  response valid; meaningful only while imem_req=1.
- imem_rdata  in  DATA_W  instruction; valid when imem_ack=1.
- stall  in  1  hazard unit: hold IF/ID contents.
- redirect  in  1  taken control transfer; flush and refetch.
- redirect_pc  in  ADDR_W  redirect target.
- oIR  out  DATA_W  IF/ID instruction.
- oPC  out  ADDR_W  address of oIR.
- oPC4  out  ADDR_W  oPC+4, used for the link-register write-back.
- ovalid  out  1  oIR is a real instruction (0 = bubble).

Behaviour:
- Reset is synchronous and active-high; one clock, clk, with reset named reset.
- Reset values: pc=RESET_PC, state=FETCH, oIR=NOP, oPC=0, oPC4=0, ovalid=0, buffer empty, pending redirect cleared. imem_req is forced to 0 while reset=1.
- Memory contract:
  - imem_req and imem_addr stay stable from assertion until the cycle with imem_ack=1.
  - ack may arrive in the same cycle as the first req cycle (zero-wait memory), or later.
- States:
  - FETCH: imem_req=1, imem_addr=pc.
  - HOLD: imem_req=0; one instruction sits in the skid buffer.
  - DROP: imem_req=1, imem_addr=pc (old address); the response will be discarded.
- Priority per cycle: reset > redirect > stall > normal advance.
- FETCH transitions:
  - ack, no stall: IF/ID <= {imem_rdata, pc, pc+4, valid=1}; pc <= pc+4; stay in FETCH. Throughput is 1 instr/cycle; IF/ID updates on the edge ending the ack cycle.
  - ack, stall: buffer <= {rdata, pc}; pc <= pc+4; go to HOLD; IF/ID holds.
  - no ack, no stall: IF/ID <= bubble (oIR=NOP, ovalid=0; oPC/oPC4 hold).
  - no ack, stall: IF/ID holds.
- HOLD transitions:
  - stall=0: IF/ID <= buffer contents with valid=1; go to FETCH.
  - stall=1: hold everything.
- Redirect, applies in every state:
  - IF/ID <= bubble next edge, even if stall=1 (flush wins).
  - Skid buffer is discarded.
  - From HOLD, or from FETCH/DROP with ack in the same cycle: pc <= redirect_pc; state FETCH.
  - From FETCH/DROP with no ack: latch redirect_pc as pending target; state DROP.
- DROP transitions:
  - On ack: discard rdata; pc <= pending target; go to FETCH.
  - A new redirect while in DROP overwrites the pending target.
- Arithmetic: pc+4 is computed in ADDR_W bits and wraps; for ADDR_W=8, 0xFC+4 = 0x00. Low two address bits are passed through unchecked.
- stall and redirect are sampled only at the clock edge. No combinational path from imem_ack to imem_req.

Decomposition:
- fetch_pkg:
  - state enum {FETCH, HOLD, DROP}.
  - PC_INC=4.
  - Default NOP constant.
- Sub-module ifid_out_reg: the IF/ID register (oIR/oPC/oPC4/ovalid) with hold and bubble-load controls. The FSM, PC and skid buffer stay in fetch_stage.

Test Plan:
1. Reset, ack tied 1, no stall/redirect → imem_addr 0x00,0x04,0x08 on consecutive cycles; oPC 0x00,0x04 one cycle later, ovalid=1, oPC4=oPC+4.
2. Ack every 3rd cycle → imem_addr held stable through wait cycles; ovalid=0 with oIR=NOP in non-ack-following cycles; no address skipped.
3. stall=1 for 4 cycles starting in an ack cycle → IF/ID frozen, state HOLD, imem_req=0. When stall drops, the buffered instruction (PC+4) appears next cycle, then fetch resumes at PC+8.
4. redirect to 0x40 while a request for 0x10 is pending and ack arrives 2 cycles later → ack data for 0x10 never reaches oIR; next imem_addr=0x40; ovalid=0 until the 0x40 instruction lands.
5. redirect and stall asserted together with valid IF/ID → ovalid=0 next cycle, buffer cleared, fetch at redirect_pc.
6. Start fetching at redirect target 0xF8 → addresses 0xF8, 0xFC, 0x00 (wrap). Reset asserted mid-DROP → all outputs return to reset values next edge; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_e : FSM encoding (FETCH / HOLD / DROP)
//   PC_INC        : byte distance between consecutive instructions
//   NOP_DEFAULT   : instruction word presented for bubbles
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  localparam int unsigned PC_INC      = 4;
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge port.
//   imem_req   : fetch request (master -> slave)
//   imem_addr  : fetch byte address (master -> slave)
//   imem_ack   : response valid, meaningful only while imem_req=1 (slave -> master)
//   imem_rdata : instruction word, valid with imem_ack (slave -> master)
interface fetch_stage_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) ();

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/ifid_out_reg.sv
// IF/ID pipeline register presented to decode.
//   clk, reset : clock and synchronous active-high reset
//   bubble_i   : load a bubble (oIR=NOP, ovalid=0, oPC/oPC4 hold); wins over load_i
//   load_i     : load a real instruction ir_i fetched from pc_i
//   ir_i, pc_i : instruction and its address
//   oIR, oPC, oPC4, ovalid : registered IF/ID contents
module ifid_out_reg
  import fetch_pkg::*;
#(
  parameter int                ADDR_W = 8,
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] NOP    = DATA_W'(NOP_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bubble_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] ir_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [DATA_W-1:0] oIR,
  output logic [ADDR_W-1:0] oPC,
  output logic [ADDR_W-1:0] oPC4,
  output logic              ovalid
);

  logic [DATA_W-1:0] ir_q;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc4_q;
  logic              valid_q;

  // IF/ID register: bubble beats load, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q    <= NOP;
      pc_q    <= {ADDR_W{1'b0}};
      pc4_q   <= {ADDR_W{1'b0}};
      valid_q <= 1'b0;
    end else if (bubble_i) begin
      // Address fields deliberately hold so decode sees a stable PC pair.
      ir_q    <= NOP;
      valid_q <= 1'b0;
    end else if (load_i) begin
      ir_q    <= ir_i;
      pc_q    <= pc_i;
      pc4_q   <= pc_i + ADDR_W'(PC_INC);
      valid_q <= 1'b1;
    end else begin
      ir_q    <= ir_q;
      pc_q    <= pc_q;
      pc4_q   <= pc4_q;
      valid_q <= valid_q;
    end
  end

  assign oIR    = ir_q;
  assign oPC    = pc_q;
  assign oPC4   = pc4_q;
  assign ovalid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS32 instruction-fetch stage: owns the PC, drives the instruction-memory
// port, keeps one instruction in a skid buffer while decode stalls, and
// flushes wrong-path work on redirect.
//   clk, reset  : clock and synchronous active-high reset
//   imem        : instruction-memory port (master side)
//   stall       : hold IF/ID contents
//   redirect    : taken control transfer, flush and refetch from redirect_pc
//   redirect_pc : redirect target
//   oIR, oPC, oPC4, ovalid : IF/ID register to decode
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter logic [DATA_W-1:0] NOP      = DATA_W'(NOP_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  fetch_stage_if.master     imem,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [DATA_W-1:0] oIR,
  output logic [ADDR_W-1:0] oPC,
  output logic [ADDR_W-1:0] oPC4,
  output logic              ovalid
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] buf_ir_q, buf_ir_d;
  logic [ADDR_W-1:0] buf_pc_q, buf_pc_d;
  logic [ADDR_W-1:0] pend_q, pend_d;

  logic              req_s;
  logic              ack_s;
  logic [ADDR_W-1:0] pc_inc_s;
  logic              ifid_bubble_s;
  logic              ifid_load_s;
  logic [DATA_W-1:0] ifid_ir_s;
  logic [ADDR_W-1:0] ifid_pc_s;

  // Request depends only on registered state, so ack never feeds back into it.
  assign req_s          = (state_q != HOLD);
  assign ack_s          = imem.imem_ack & req_s;
  assign pc_inc_s       = pc_q + ADDR_W'(PC_INC);
  assign imem.imem_req  = req_s & ~reset;
  assign imem.imem_addr = pc_q;

  // Next-state logic: redirect > stall > normal advance.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    buf_ir_d      = buf_ir_q;
    buf_pc_d      = buf_pc_q;
    pend_d        = pend_q;
    ifid_bubble_s = 1'b0;
    ifid_load_s   = 1'b0;
    ifid_ir_s     = imem.imem_rdata;
    ifid_pc_s     = pc_q;

    if (redirect) begin
      ifid_bubble_s = 1'b1;
      buf_ir_d      = {DATA_W{1'b0}};
      buf_pc_d      = {ADDR_W{1'b0}};
      // An outstanding request that has not been acked must still complete
      // (address held stable), so its response is dropped before refetching.
      if ((state_q == HOLD) || ack_s) begin
        pc_d    = redirect_pc;
        state_d = FETCH;
      end else begin
        pend_d  = redirect_pc;
        state_d = DROP;
      end
    end else begin
      case (state_q)
        FETCH: begin
          if (ack_s) begin
            pc_d = pc_inc_s;
            if (stall) begin
              buf_ir_d = imem.imem_rdata;
              buf_pc_d = pc_q;
              state_d  = HOLD;
            end else begin
              ifid_load_s = 1'b1;
            end
          end else if (!stall) begin
            ifid_bubble_s = 1'b1;
          end else begin
            ifid_bubble_s = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            ifid_load_s = 1'b1;
            ifid_ir_s   = buf_ir_q;
            ifid_pc_s   = buf_pc_q;
            state_d     = FETCH;
          end else begin
            state_d = HOLD;
          end
        end
        DROP: begin
          // IF/ID already holds the flush bubble; only wait for the stale ack.
          if (ack_s) begin
            pc_d    = pend_q;
            state_d = FETCH;
          end else begin
            state_d = DROP;
          end
        end
        default: begin
          state_d = FETCH;
        end
      endcase
    end
  end

  // State, PC, skid buffer and pending redirect target.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      buf_ir_q <= {DATA_W{1'b0}};
      buf_pc_q <= {ADDR_W{1'b0}};
      pend_q   <= {ADDR_W{1'b0}};
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      buf_ir_q <= buf_ir_d;
      buf_pc_q <= buf_pc_d;
      pend_q   <= pend_d;
    end
  end

  ifid_out_reg #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .NOP    (NOP)
  ) u_ifid (
    .clk      (clk),
    .reset    (reset),
    .bubble_i (ifid_bubble_s),
    .load_i   (ifid_load_s),
    .ir_i     (ifid_ir_s),
    .pc_i     (ifid_pc_s),
    .oIR      (oIR),
    .oPC      (oPC),
    .oPC4     (oPC4),
    .ovalid   (ovalid)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed stimulus pushes the expected
// IF/ID contents; a negedge monitor pops and compares each newly presented
// valid instruction. Memory returns 0xC0DE_00<addr> for every address.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       stall;
  logic       redirect;
  logic [7:0] redirect_pc;
  logic [31:0] oIR;
  logic [7:0]  oPC;
  logic [7:0]  oPC4;
  logic        ovalid;

  always #5 clk = ~clk;

  fetch_stage_if #(.ADDR_W(8), .DATA_W(32)) imem ();

  assign imem.imem_rdata = 32'hC0DE_0000 | {24'h0, imem.imem_addr};

  fetch_stage #(
    .ADDR_W   (8),
    .DATA_W   (32),
    .RESET_PC (8'h00),
    .NOP      (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem        (imem),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .oIR         (oIR),
    .oPC         (oPC),
    .oPC4        (oPC4),
    .ovalid      (ovalid)
  );

  typedef struct packed {
    logic [7:0]  pc;
    logic [7:0]  pc4;
    logic [31:0] ir;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] pc, input logic [7:0] pc4, input logic [31:0] ir);
    exp_t e;
    e.pc  = pc;
    e.pc4 = pc4;
    e.ir  = ir;
    sb_q.push_back(e);
  endtask

  // One clock cycle with the given inputs; returns 1 time unit after the edge.
  task automatic drive(input logic ack, input logic stl, input logic rdr, input logic [7:0] rpc);
    imem.imem_ack = ack;
    stall         = stl;
    redirect      = rdr;
    redirect_pc   = rpc;
    @(posedge clk);
    #1;
  endtask

  // Monitor: a new IF/ID presentation is a valid word differing from the last sample.
  logic        prev_v = 1'b0;
  logic [7:0]  prev_pc = 8'h00;
  logic [31:0] prev_ir = 32'h0;
  exp_t        mon_e;

  always @(negedge clk) begin
    if (!reset && ovalid && (!prev_v || oPC !== prev_pc || oIR !== prev_ir)) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got pc %h ir %h, expected nothing", oPC, oIR);
      end else begin
        mon_e = sb_q.pop_front();
        check("sb_ir",  oIR, mon_e.ir);
        check("sb_pc",  {24'h0, oPC},  {24'h0, mon_e.pc});
        check("sb_pc4", {24'h0, oPC4}, {24'h0, mon_e.pc4});
      end
    end
    prev_v  = ovalid && !reset;
    prev_pc = oPC;
    prev_ir = oIR;
  end

  initial begin
    reset         = 1'b1;
    imem.imem_ack = 1'b0;
    stall         = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = 8'h00;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check("rst_req",    {31'h0, imem.imem_req}, 32'h0);
    check("rst_ovalid", {31'h0, ovalid}, 32'h0);
    check("rst_oIR",    oIR, 32'h0);
    check("rst_oPC",    {24'h0, oPC},  32'h0);
    check("rst_oPC4",   {24'h0, oPC4}, 32'h0);
    reset = 1'b0;
    #1;

    // 1: zero-wait streaming
    check("t1_req",   {31'h0, imem.imem_req}, 32'h1);
    check("t1_addr0", {24'h0, imem.imem_addr}, 32'h00);
    push(8'h00, 8'h04, 32'hC0DE_0000);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    check("t1_addr1", {24'h0, imem.imem_addr}, 32'h04);
    check("t1_valid", {31'h0, ovalid}, 32'h1);
    push(8'h04, 8'h08, 32'hC0DE_0004);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    check("t1_addr2", {24'h0, imem.imem_addr}, 32'h08);
    push(8'h08, 8'h0C, 32'hC0DE_0008);
    drive(1'b1, 1'b0, 1'b0, 8'h00);

    // 2: ack every third cycle
    check("t2_addr_a0", {24'h0, imem.imem_addr}, 32'h0C);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check("t2_bubble_v",  {31'h0, ovalid}, 32'h0);
    check("t2_bubble_ir", oIR, 32'h0);
    check("t2_bubble_pc", {24'h0, oPC}, 32'h08);
    check("t2_addr_a1", {24'h0, imem.imem_addr}, 32'h0C);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check("t2_addr_a2", {24'h0, imem.imem_addr}, 32'h0C);
    push(8'h0C, 8'h10, 32'hC0DE_000C);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    check("t2_addr_b0", {24'h0, imem.imem_addr}, 32'h10);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check("t2_bubble2_v", {31'h0, ovalid}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check("t2_addr_b2", {24'h0, imem.imem_addr}, 32'h10);
    push(8'h10, 8'h14, 32'hC0DE_0010);
    drive(1'b1, 1'b0, 1'b0, 8'h00);

    // 3: stall for 4 cycles starting in an ack cycle
    check("t3_addr", {24'h0, imem.imem_addr}, 32'h14);
    drive(1'b1, 1'b1, 1'b0, 8'h00);
    check("t3_hold_req", {31'h0, imem.imem_req}, 32'h0);
    check("t3_hold_pc",  {24'h0, oPC}, 32'h10);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 1'b0, 8'h00);
    check("t3_frozen_pc", {24'h0, oPC}, 32'h10);
    check("t3_frozen_v",  {31'h0, ovalid}, 32'h1);
    check("t3_frozen_req", {31'h0, imem.imem_req}, 32'h0);
    push(8'h14, 8'h18, 32'hC0DE_0014);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check("t3_resume_addr", {24'h0, imem.imem_addr}, 32'h18);
    check("t3_resume_req",  {31'h0, imem.imem_req}, 32'h1);
    push(8'h18, 8'h1C, 32'hC0DE_0018);
    drive(1'b1, 1'b0, 1'b0, 8'h00);

    // 5: redirect + stall with valid IF/ID and ack in the same cycle
    check("t5_pre_v", {31'h0, ovalid}, 32'h1);
    drive(1'b1, 1'b1, 1'b1, 8'h10);
    check("t5_flush_v",  {31'h0, ovalid}, 32'h0);
    check("t5_flush_ir", oIR, 32'h0);
    check("t5_addr",     {24'h0, imem.imem_addr}, 32'h10);
    check("t5_req",      {31'h0, imem.imem_req}, 32'h1);

    // 4: redirect to 0x40 while 0x10 is outstanding; stale ack two cycles later
    drive(1'b0, 1'b0, 1'b1, 8'h40);
    check("t4_drop_addr", {24'h0, imem.imem_addr}, 32'h10);
    check("t4_drop_req",  {31'h0, imem.imem_req}, 32'h1);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check("t4_drop_addr2", {24'h0, imem.imem_addr}, 32'h10);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    check("t4_new_addr", {24'h0, imem.imem_addr}, 32'h40);
    check("t4_still_bubble", {31'h0, ovalid}, 32'h0);
    push(8'h40, 8'h44, 32'hC0DE_0040);
    drive(1'b1, 1'b0, 1'b0, 8'h00);

    // 6: overwritten pending target 0xF8, then wrap through 0xFC
    drive(1'b0, 1'b0, 1'b1, 8'h80);
    drive(1'b0, 1'b0, 1'b1, 8'hF8);
    check("t6_drop_addr", {24'h0, imem.imem_addr}, 32'h44);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    check("t6_addr_f8", {24'h0, imem.imem_addr}, 32'hF8);
    push(8'hF8, 8'hFC, 32'hC0DE_00F8);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    check("t6_addr_fc", {24'h0, imem.imem_addr}, 32'hFC);
    push(8'hFC, 8'h00, 32'hC0DE_00FC);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    check("t6_pc4_wrap", {24'h0, oPC4}, 32'h00);
    check("t6_addr_00", {24'h0, imem.imem_addr}, 32'h00);
    push(8'h00, 8'h04, 32'hC0DE_0000);
    drive(1'b1, 1'b0, 1'b0, 8'h00);

    // 6b: reset in the middle of DROP
    drive(1'b0, 1'b0, 1'b1, 8'h60);
    check("t6_drop_v", {31'h0, ovalid}, 32'h0);
    reset = 1'b1;
    #1;
    check("t6_rst_req_comb", {31'h0, imem.imem_req}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    check("t6_rst_v",    {31'h0, ovalid}, 32'h0);
    check("t6_rst_ir",   oIR, 32'h0);
    check("t6_rst_pc",   {24'h0, oPC},  32'h0);
    check("t6_rst_pc4",  {24'h0, oPC4}, 32'h0);
    check("t6_rst_addr", {24'h0, imem.imem_addr}, 32'h00);
    reset = 1'b0;
    #1;
    check("t6_restart_req",  {31'h0, imem.imem_req}, 32'h1);
    check("t6_restart_addr", {24'h0, imem.imem_addr}, 32'h00);
    push(8'h00, 8'h04, 32'hC0DE_0000);
    drive(1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    check("sb_drained", sb_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
